io_output_buffer: RTL and testbench

IO_OUTPUT_BUFFER -- requirements
Module: io_output_buffer

---
 rtl/io_output_buffer_pkg.sv | 21 ++
 rtl/io_fifo_mem.sv | 23 ++
 rtl/io_output_buffer.sv | 85 ++++++++
 tb/tb_io_output_buffer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/io_output_buffer_pkg.sv
// Shared defines (WORD_SIZE, IO_OUT_DEPTH) and package for the IO output buffer.
// Optional feature macro: IO_OUT_DROP_COUNT_EN (adds the drop_count port).
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef IO_OUT_DEPTH
`define IO_OUT_DEPTH 8
`endif

package io_output_buffer_pkg;
  localparam int WORD_W        = `WORD_SIZE;
  localparam int DEFAULT_DEPTH = `IO_OUT_DEPTH;
  localparam int DROP_W        = 8;

  typedef logic [WORD_W-1:0] word_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/io_fifo_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous read port.
module io_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers and count,
  // so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/io_output_buffer.sv
// First-word fall-through output buffer between the IO decoder and a ready/valid consumer.
// Define IO_OUT_DROP_COUNT_EN to add the saturating drop_count output.
module io_output_buffer
  import io_output_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      out_write,
  input  logic [`WORD_SIZE-1:0]     io_out,
  input  logic                      flush,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [`WORD_SIZE-1:0]     tx_data,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty,
  output logic                      overflow
`ifdef IO_OUT_DROP_COUNT_EN
  ,
  output logic [DROP_W-1:0]         drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic          push, pop, drop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign tx_valid = ~empty;
  assign count    = count_q;
  assign overflow = overflow_q;

  // A pop frees a slot in the same edge, so a full buffer still accepts a push.
  assign pop  = tx_valid & tx_ready;
  assign push = out_write & (~full | pop);
  assign drop = out_write & full & ~pop;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end

`ifdef IO_OUT_DROP_COUNT_EN
  always_ff @(posedge clk or negedge areset) begin
    if (!areset)   drop_count <= '0;
    else if (flush) drop_count <= '0;
    else if (drop)  drop_count <= sat_inc(drop_count);
  end
`endif

  io_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (`WORD_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~flush),
    .waddr (wr_ptr),
    .wdata (io_out),
    .raddr (rd_ptr),
    .rdata (tx_data)
  );
endmodule

// File: tb/tb_io_output_buffer.sv
// Self-checking bench for io_output_buffer: queue scoreboard of accepted words,
// popped and compared against tx_data whenever a pop happens.
`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
module tb_io_output_buffer;
  localparam int DEPTH = 8;
  localparam int W     = `WORD_SIZE;

  logic         clk = 1'b0;
  logic         areset;
  logic         out_write, flush, tx_ready;
  logic [W-1:0] io_out;
  logic         tx_valid, full, empty, overflow;
  logic [W-1:0] tx_data;
  logic [3:0]   count;
`ifdef IO_OUT_DROP_COUNT_EN
  logic [7:0]   drop_count;
`endif

  io_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .areset    (areset),
    .out_write (out_write),
    .io_out    (io_out),
    .flush     (flush),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow)
`ifdef IO_OUT_DROP_COUNT_EN
    ,
    .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] q[$];
  bit           m_ovf;
  int           m_drop;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic check_state();
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("empty", 32'(empty), 32'(q.size() == 0));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("count_le_depth", 32'(count <= DEPTH), 32'd1);
`ifdef IO_OUT_DROP_COUNT_EN
    check("drop_count", 32'(drop_count), 32'(m_drop));
`endif
  endtask

  task automatic model_clear();
    q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // Called just after a falling edge: drive, check the head, clock, check state.
  task automatic step(input bit wr, input logic [W-1:0] d, input bit rdy, input bit fl);
    bit pop_m, full_m;
    out_write = wr; io_out = d; tx_ready = rdy; flush = fl;
    #1;
    check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("tx_data", 32'(tx_data), 32'(q[0]));
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      pop_m  = rdy && (q.size() > 0);
      full_m = (q.size() == DEPTH);
      if (pop_m) void'(q.pop_front());
      if (wr && (!full_m || pop_m)) q.push_back(d);
      else if (wr) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    #1;
    check_state();
    @(negedge clk);
    out_write = 1'b0; tx_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    areset = 1'b0; out_write = 1'b0; flush = 1'b0; tx_ready = 1'b0; io_out = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    areset = 1'b1;

    // Single push into empty buffer, consumer stalled; first edge after reset.
    step(1'b1, W'('h0005), 1'b0, 1'b0);
    check("first_word", 32'(tx_data), 32'h5);
    step(1'b0, '0, 1'b0, 1'b0);
    drain();

    // Fill to full, then one dropped push; overflow stays set after draining.
    for (int i = 1; i <= 8; i++) step(1'b1, W'(i), 1'b0, 1'b0);
    step(1'b1, W'(9), 1'b0, 1'b0);
    drain();
    check("overflow_sticky", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Push and pop together while full: no drop, 0xAA becomes the tail.
    for (int i = 0; i < 8; i++) step(1'b1, W'('h10 + i), 1'b0, 1'b0);
    step(1'b1, W'('hAA), 1'b1, 1'b0);
    check("full_pushpop_ovf", 32'(overflow), 32'd0);
    drain();

    // Push every cycle, pop every other cycle: pointer wrap and drops when full.
    for (int i = 0; i < 20; i++) step(1'b1, W'('h100 + i), 1'(i % 2), 1'b0);
    drain();
    step(1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset between clock edges discards contents immediately.
    for (int i = 0; i < 4; i++) step(1'b1, W'('h200 + i), 1'b0, 1'b0);
    #2 areset = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_clear();
    @(negedge clk);
    areset = 1'b1;
    step(1'b1, W'('h0301), 1'b0, 1'b0);
    drain();

    // Flush takes priority over a simultaneous push and pop.
    for (int i = 0; i < 8; i++) step(1'b1, W'('h400 + i), 1'b0, 1'b0);
    step(1'b1, W'('h4FF), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
    check("pre_flush_count", 32'(count), 32'd3);
    step(1'b1, W'('h0777), 1'b1, 1'b1);
    check_reset_values("flush");
    step(1'b0, '0, 1'b0, 1'b0);

`ifdef IO_OUT_DROP_COUNT_EN
    for (int i = 0; i < 8; i++) step(1'b1, W'('h500 + i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(1'b1, W'('h600 + i), 1'b0, 1'b0);
    check("drop_sat", 32'(drop_count), 32'd255);
    #2 areset = 1'b0;
    #1;
    check("drop_reset", 32'(drop_count), 32'd0);
    check_reset_values("drop_reset");
    model_clear();
    @(negedge clk);
    areset = 1'b1;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
